// File: rtl/parity_stream_checker.sv
// rtl/parity_stream_checker.sv - serial frame parity checker with saturating error counter
//
// Receives frames of DATA_W data bits (LSB first) followed by one parity bit,
// checks even (ODD=0) or odd (ODD=1) parity and counts erroneous frames.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   bit_in      serial frame bit, sampled only when bit_valid=1
//   bit_valid   qualifies bit_in
//   abort       discard any partial frame (synchronous)
//   clr_cnt     clear err_cnt (synchronous, wins over increment)
//   busy        frame partially received
//   done        one-cycle pulse, frame complete
//   parity_err  check result of the last completed frame
//   data_out    data word of the last completed frame
//   err_cnt     saturating count of frames with parity_err=1
module parity_stream_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              abort,
  input  logic              clr_cnt,
  output logic              busy,
  output logic              done,
  output logic              parity_err,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] PARITY_IDX = IDX_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic                done_nxt;
  logic                perr_nxt;
  logic [DATA_W-1:0]   dout_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      done       <= 1'b0;
      parity_err <= 1'b0;
      data_out   <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      shreg      <= shreg_nxt;
      done       <= done_nxt;
      parity_err <= perr_nxt;
      data_out   <= dout_nxt;
      err_cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    perr_nxt  = parity_err;
    dout_nxt  = data_out;
    cnt_nxt   = err_cnt;
    // Parity over the stored data word plus the incoming (parity) bit.
    x         = (^shreg) ^ bit_in;

    if (abort) begin
      // Abort beats any bit presented in the same cycle, including the parity bit.
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (bit_valid) begin
      case (state)
        IDLE: begin
          // Clear stale bits of the previous frame while loading bit 0.
          shreg_nxt    = '0;
          shreg_nxt[0] = bit_in;
          idx_nxt      = IDX_W'(1);
          state_nxt    = SHIFT;
        end
        SHIFT: begin
          if (idx == PARITY_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
            perr_nxt  = (ODD != 0) ? ~x : x;
            dout_nxt  = shreg;
            if (perr_nxt && (err_cnt != CNT_MAX)) begin
              cnt_nxt = err_cnt + 1'b1;
            end
          end else begin
            shreg_nxt[idx] = bit_in;
            idx_nxt        = idx + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      endcase
    end

    if (clr_cnt) begin
      cnt_nxt = '0;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_parity_stream_checker.sv
// tb/tb_parity_stream_checker.sv - testbench for parity_stream_checker
//
// Two instances share all inputs: dut_e (even parity, 2-bit counter) and
// dut_o (odd parity, 8-bit counter). A frame-level reference model built on a
// bit queue predicts every output of both instances after every clock edge.
module tb_parity_stream_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       abort = 1'b0;
  logic       clr_cnt = 1'b0;

  logic       busy_e, done_e, perr_e;
  logic [7:0] data_e;
  logic [1:0] cnt_e;
  logic       busy_o, done_o, perr_o;
  logic [7:0] data_o;
  logic [7:0] cnt_o;

  parity_stream_checker #(.DATA_W(8), .ODD(0), .CNT_W(2)) dut_e (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .abort(abort), .clr_cnt(clr_cnt), .busy(busy_e), .done(done_e),
    .parity_err(perr_e), .data_out(data_e), .err_cnt(cnt_e)
  );

  parity_stream_checker #(.DATA_W(8), .ODD(1), .CNT_W(8)) dut_o (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .abort(abort), .clr_cnt(clr_cnt), .busy(busy_o), .done(done_o),
    .parity_err(perr_o), .data_out(data_o), .err_cnt(cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  // Reference model state
  bit         frame_q[$];
  logic [7:0] m_data;
  logic       m_err_e, m_err_o, m_done;
  int         m_cnt_e, m_cnt_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    frame_q.delete();
    m_data  = '0;
    m_err_e = 1'b0;
    m_err_o = 1'b0;
    m_done  = 1'b0;
    m_cnt_e = 0;
    m_cnt_o = 0;
  endfunction

  function automatic void model_edge(input bit b, input bit v, input bit ab, input bit cl);
    int  ones;
    bit  inc_e, inc_o;
    inc_e  = 1'b0;
    inc_o  = 1'b0;
    m_done = 1'b0;
    if (ab) begin
      frame_q.delete();
    end else if (v) begin
      if (frame_q.size() == 8) begin
        ones = int'(b);
        for (int i = 0; i < 8; i++) begin
          m_data[i] = frame_q[i];
          ones += int'(frame_q[i]);
        end
        m_err_e = (ones % 2) == 1;
        m_err_o = (ones % 2) == 0;
        m_done  = 1'b1;
        inc_e   = m_err_e;
        inc_o   = m_err_o;
        frame_q.delete();
      end else begin
        frame_q.push_back(b);
      end
    end
    if (cl) begin
      m_cnt_e = 0;
      m_cnt_o = 0;
    end else begin
      if (inc_e && m_cnt_e < 3)   m_cnt_e++;
      if (inc_o && m_cnt_o < 255) m_cnt_o++;
    end
  endfunction

  task automatic compare_all();
    logic exp_busy;
    exp_busy = (frame_q.size() != 0);
    if (done_e === 1'b1) done_seen++;
    chk("busy_e", 32'(busy_e), 32'(exp_busy));
    chk("done_e", 32'(done_e), 32'(m_done));
    chk("perr_e", 32'(perr_e), 32'(m_err_e));
    chk("data_e", 32'(data_e), 32'(m_data));
    chk("cnt_e",  32'(cnt_e),  32'(m_cnt_e));
    chk("busy_o", 32'(busy_o), 32'(exp_busy));
    chk("done_o", 32'(done_o), 32'(m_done));
    chk("perr_o", 32'(perr_o), 32'(m_err_o));
    chk("data_o", 32'(data_o), 32'(m_data));
    chk("cnt_o",  32'(cnt_o),  32'(m_cnt_o));
  endtask

  task automatic step(input bit b, input bit v, input bit ab, input bit cl);
    bit_in    = b;
    bit_valid = v;
    abort     = ab;
    clr_cnt   = cl;
    @(posedge clk);
    model_edge(b, v, ab, cl);
    #1;
    compare_all();
  endtask

  // Reset pulse asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    bit_valid = 1'b0;
    abort     = 1'b0;
    clr_cnt   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all();
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(gap_max, 0); g > 0; g--) step(1'($urandom), 1'b0, 1'b0, 1'b0);
      step(d[i], 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par, input int gap_max,
                            input bit clr_par, input bit abort_par);
    send_bits(d, 8, gap_max);
    for (int g = $urandom_range(gap_max, 0); g > 0; g--) step(1'($urandom), 1'b0, 1'b0, 1'b0);
    step(par, 1'b1, abort_par, clr_par);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         par;
    int         gap_max;
    logic       exp_err_e;
    logic       exp_err_o;
  } vec_t;

  vec_t vecs[8];
  int   exp_cnt_seq[5];
  int   d0;
  int   cnt_before;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 0, 1'b0, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 0, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 5, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 2, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 3, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 1'b1, 1, 1'b0, 1'b1};
    vecs[7] = '{8'h80, 1'b0, 0, 1'b1, 1'b0};
    exp_cnt_seq = '{1, 2, 3, 3, 3};

    // Power-on reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // First frame: 0xA5, even parity bit 0
    send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0);
    chk("a5_done", 32'(done_e), 32'd1);
    chk("a5_data", 32'(data_e), 32'hA5);
    chk("a5_perr", 32'(perr_e), 32'd0);
    chk("a5_cnt",  32'(cnt_e),  32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_done_low", 32'(done_e), 32'd0);

    // Table of frames
    for (int k = 0; k < 8; k++) begin
      d0 = done_seen;
      send_frame(vecs[k].data, vecs[k].par, vecs[k].gap_max, 1'b0, 1'b0);
      chk("tbl_done",   32'(done_e), 32'd1);
      chk("tbl_data_e", 32'(data_e), 32'(vecs[k].data));
      chk("tbl_data_o", 32'(data_o), 32'(vecs[k].data));
      chk("tbl_perr_e", 32'(perr_e), 32'(vecs[k].exp_err_e));
      chk("tbl_perr_o", 32'(perr_o), 32'(vecs[k].exp_err_o));
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("tbl_one_done", 32'(done_seen - d0), 32'd1);
    end

    // Abort after 5 data bits, then a full 0x01 frame with parity 1
    do_reset();
    d0 = done_seen;
    send_bits(8'hFF, 5, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_busy", 32'(busy_e), 32'd0);
    send_frame(8'h01, 1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_single_done", 32'(done_seen - d0), 32'd1);
    chk("abort_data", 32'(data_e), 32'h01);
    chk("abort_perr", 32'(perr_e), 32'd0);

    // Abort on the parity cycle: no done, no count change
    cnt_before = int'(cnt_o);
    send_frame(8'h00, 1'b0, 0, 1'b0, 1'b1);
    chk("abort_par_done", 32'(done_e), 32'd0);
    chk("abort_par_cnt",  32'(cnt_o),  32'(cnt_before));
    chk("abort_par_data", 32'(data_e), 32'h01);

    // Saturating 2-bit counter with back-to-back erroneous frames
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
      chk("sat_cnt", 32'(cnt_e), 32'(exp_cnt_seq[k]));
    end
    send_frame(8'hA5, 1'b1, 0, 1'b1, 1'b0);
    chk("clr_wins", 32'(cnt_e), 32'd0);
    chk("clr_done", 32'(done_e), 32'd1);

    // Reset mid-frame after 3 data bits, then 0xFF with parity 0
    send_bits(8'h07, 3, 0);
    do_reset();
    send_frame(8'hFF, 1'b0, 0, 1'b0, 1'b0);
    chk("rst_data", 32'(data_e), 32'hFF);
    chk("rst_perr", 32'(perr_e), 32'd0);
    chk("rst_cnt",  32'(cnt_e),  32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299, 0) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom), $urandom_range(9, 0) < 7,
             $urandom_range(39, 0) == 0, $urandom_range(59, 0) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
